// File: rtl/phy_tx_framer_if.sv
// -----------------------------------------------------------------------------
// phy_tx_framer_if
// Bundles the user-side AXI-Stream transmit channel and the GT transmit bus of
// the PHY transmit framer.
//   i_tx_axis_data  [31:0]  payload beat, [31:24] is the first byte on the wire
//   i_tx_axis_keep  [3:0]   byte enables (only the last beat may be partial)
//   i_tx_axis_valid         beat valid
//   i_tx_axis_last          final beat of the frame
//   o_tx_axis_ready         beat accepted when valid && ready
//   o_gt_tx_data    [31:0]  GT data, lane 0 = [7:0] sent first
//   o_gt_tx_char    [3:0]   per-lane K flag
//   o_tx_underrun           one-cycle pulse on a mid-frame abort
// Modports: master = frame source, slave = framer.
// -----------------------------------------------------------------------------
interface phy_tx_framer_if;
    logic [31:0] i_tx_axis_data;
    logic [3:0]  i_tx_axis_keep;
    logic        i_tx_axis_valid;
    logic        i_tx_axis_last;
    logic        o_tx_axis_ready;
    logic [31:0] o_gt_tx_data;
    logic [3:0]  o_gt_tx_char;
    logic        o_tx_underrun;

    modport master (
        output i_tx_axis_data, i_tx_axis_keep, i_tx_axis_valid, i_tx_axis_last,
        input  o_tx_axis_ready, o_gt_tx_data, o_gt_tx_char, o_tx_underrun
    );

    modport slave (
        input  i_tx_axis_data, i_tx_axis_keep, i_tx_axis_valid, i_tx_axis_last,
        output o_tx_axis_ready, o_gt_tx_data, o_gt_tx_char, o_tx_underrun
    );
endinterface

// File: rtl/phy_tx_framer.sv
// -----------------------------------------------------------------------------
// phy_tx_framer
// Transmit-side framer of the GT PHY. Wraps each AXI-Stream frame as
// FB(K) + payload + FD(K), separated by idle comma words (BC(K),50,BC(K),50).
// A one-byte residual register realigns the 4-byte beats: every output word is
// {residual, next 3 bytes} in wire order and the 4th byte becomes the residual.
//
// Ports:
//   i_clk   GT user clock, rising edge
//   i_rst   asynchronous active-high reset
//   tx_if   phy_tx_framer_if.slave (AXIS input channel, GT output bus)
// Parameters:
//   P_IFG_WORDS  idle words after each EOF word before the next frame (1..15)
// Optional build macro:
//   PHY_TX_UNDERRUN_ABORT_EN  valid low mid-frame terminates the frame with FD,
//                             pulses o_tx_underrun and drops the rest of it.
// -----------------------------------------------------------------------------
module phy_tx_framer #(
    parameter int P_IFG_WORDS = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    phy_tx_framer_if.slave tx_if
);

    localparam logic [7:0]  K_SOF     = 8'hFB;
    localparam logic [7:0]  K_EOF     = 8'hFD;
    localparam logic [7:0]  K_COMMA   = 8'hBC;
    localparam logic [7:0]  D_IDLE    = 8'h50;
    localparam logic [31:0] IDLE_WORD = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_CHAR = 4'b0101;
    localparam logic [3:0]  IFG_LAST  = 4'(P_IFG_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IFG  = 3'd0,
        ST_IDLE = 3'd1,
        ST_DATA = 3'd2,
        ST_TAIL = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // Number of valid bytes on a last beat; illegal patterns count as full.
    function automatic logic [2:0] keep_to_len(input logic [3:0] keep);
        logic [2:0] len;
        case (keep)
            4'hF:    len = 3'd4;
            4'hE:    len = 3'd3;
            4'hC:    len = 3'd2;
            4'h8:    len = 3'd1;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  ifg_cnt_r, ifg_cnt_s;
    logic [7:0]  res_r, res_s;
    logic        tail_full_r, tail_full_s;
    logic [31:0] data_r, data_s;
    logic [3:0]  char_r, char_s;
    logic        ready_r, ready_s;

    logic        accept_s;
    logic [2:0]  len_s;
    logic [7:0]  res_byte_s;
    logic        res_k_s;
    logic [7:0]  b0_s, b1_s, b2_s, b3_s;

`ifdef PHY_TX_UNDERRUN_ABORT_EN
    logic        underrun_r, underrun_s;
`endif

    assign accept_s   = tx_if.i_tx_axis_valid && ready_r;
    assign len_s      = tx_if.i_tx_axis_last ? keep_to_len(tx_if.i_tx_axis_keep) : 3'd4;
    assign b0_s       = tx_if.i_tx_axis_data[31:24];
    assign b1_s       = tx_if.i_tx_axis_data[23:16];
    assign b2_s       = tx_if.i_tx_axis_data[15:8];
    assign b3_s       = tx_if.i_tx_axis_data[7:0];
    // In IDLE the accepted beat is the SOF beat, so the residual slot holds FB(K).
    assign res_k_s    = (state_r == ST_IDLE);
    assign res_byte_s = res_k_s ? K_SOF : res_r;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s     = state_r;
        ifg_cnt_s   = ifg_cnt_r;
        res_s       = res_r;
        tail_full_s = tail_full_r;
        data_s      = IDLE_WORD;
        char_s      = IDLE_CHAR;
`ifdef PHY_TX_UNDERRUN_ABORT_EN
        underrun_s  = 1'b0;
`endif
        case (state_r)
            ST_IFG: begin
                if (ifg_cnt_r == IFG_LAST) begin
                    state_s   = ST_IDLE;
                    ifg_cnt_s = 4'd0;
                end else begin
                    ifg_cnt_s = ifg_cnt_r + 4'd1;
                end
            end
            ST_IDLE, ST_DATA: begin
                if (accept_s) begin
                    // Word for this beat; short last beats carry FD and pads here.
                    case (len_s)
                        3'd1: begin
                            data_s = {D_IDLE, K_EOF, b0_s, res_byte_s};
                            char_s = {1'b0, 1'b1, 1'b0, res_k_s};
                        end
                        3'd2: begin
                            data_s = {K_EOF, b1_s, b0_s, res_byte_s};
                            char_s = {1'b1, 1'b0, 1'b0, res_k_s};
                        end
                        default: begin
                            data_s = {b2_s, b1_s, b0_s, res_byte_s};
                            char_s = {1'b0, 1'b0, 1'b0, res_k_s};
                        end
                    endcase
                    if (!tx_if.i_tx_axis_last) begin
                        res_s   = b3_s;
                        state_s = ST_DATA;
                    end else if (len_s <= 3'd2) begin
                        state_s   = ST_IFG;
                        ifg_cnt_s = 4'd0;
                    end else begin
                        // Three or four bytes leave FD (and maybe b3) for a tail word.
                        res_s       = b3_s;
                        tail_full_s = (len_s == 3'd4);
                        state_s     = ST_TAIL;
                    end
                end else if (state_r == ST_DATA) begin
`ifdef PHY_TX_UNDERRUN_ABORT_EN
                    data_s     = {D_IDLE, K_COMMA, K_EOF, res_r};
                    char_s     = 4'b0110;
                    underrun_s = 1'b1;
                    state_s    = ST_DROP;
`else
                    // Source stalled mid-frame: idle word, residual and state held.
                    state_s = ST_DATA;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TAIL: begin
                if (tail_full_r) begin
                    data_s = {D_IDLE, K_COMMA, K_EOF, res_r};
                    char_s = 4'b0110;
                end else begin
                    data_s = {D_IDLE, K_COMMA, D_IDLE, K_EOF};
                    char_s = 4'b0101;
                end
                state_s   = ST_IFG;
                ifg_cnt_s = 4'd0;
            end
            ST_DROP: begin
                // Discard the aborted frame up to and including its last beat.
                if (accept_s && tx_if.i_tx_axis_last) begin
                    state_s   = ST_IFG;
                    ifg_cnt_s = 4'd0;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s   = ST_IFG;
                ifg_cnt_s = 4'd0;
            end
        endcase
    end

    // Ready is registered from the next state so it always matches state_r.
    always_comb begin
        ready_s = (state_s == ST_IDLE) || (state_s == ST_DATA) || (state_s == ST_DROP);
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= ST_IFG;
            ifg_cnt_r   <= 4'd0;
            res_r       <= 8'd0;
            tail_full_r <= 1'b0;
            data_r      <= IDLE_WORD;
            char_r      <= IDLE_CHAR;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            ifg_cnt_r   <= ifg_cnt_s;
            res_r       <= res_s;
            tail_full_r <= tail_full_s;
            data_r      <= data_s;
            char_r      <= char_s;
            ready_r     <= ready_s;
        end
    end

`ifdef PHY_TX_UNDERRUN_ABORT_EN
    // Underrun pulse register, aligned with the FD abort word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_s;
        end
    end
    assign tx_if.o_tx_underrun = underrun_r;
`else
    assign tx_if.o_tx_underrun = 1'b0;
`endif

    assign tx_if.o_gt_tx_data    = data_r;
    assign tx_if.o_gt_tx_char    = char_r;
    assign tx_if.o_tx_axis_ready = ready_r;

endmodule

// File: tb/tb_phy_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_framer
// Directed frames drive the framer; every expected non-idle GT word is queued
// with a hand-computed value and checked by an independent monitor, which also
// counts the idle words preceding each word where the gap is fixed.
// -----------------------------------------------------------------------------
module tb_phy_tx_framer;

    localparam logic [31:0] IDLE_W = 32'h50BC50BC;
    localparam logic [3:0]  IDLE_C = 4'b0101;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  c;
        logic        u;
        int          gap;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   idle_cnt = 0;
    exp_t q[$];
    exp_t e;

    phy_tx_framer_if tx_if ();

    phy_tx_framer #(.P_IFG_WORDS(2)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .tx_if (tx_if)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] c, input logic u, input int gap);
        exp_t x;
        x.d = d; x.c = c; x.u = u; x.gap = gap;
        q.push_back(x);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int bound = 0;
        tx_if.i_tx_axis_data  = d;
        tx_if.i_tx_axis_keep  = k;
        tx_if.i_tx_axis_last  = l;
        tx_if.i_tx_axis_valid = 1'b1;
        while (!tx_if.o_tx_axis_ready && bound < 100) begin
            @(posedge i_clk); #1;
            bound++;
        end
        if (bound >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready stayed 0 for %0d cycles", bound);
        end
        @(posedge i_clk); #1;
        tx_if.i_tx_axis_valid = 1'b0;
        tx_if.i_tx_axis_last  = 1'b0;
    endtask

    // Monitor: every non-idle word must match the head of the expectation queue.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (tx_if.o_gt_tx_data == IDLE_W && tx_if.o_gt_tx_char == IDLE_C && !tx_if.o_tx_underrun) begin
                idle_cnt++;
            end else begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h/%b u=%b expected none",
                             tx_if.o_gt_tx_data, tx_if.o_gt_tx_char, tx_if.o_tx_underrun);
                end else begin
                    e = q.pop_front();
                    chk("gt_data", tx_if.o_gt_tx_data, e.d);
                    chk("gt_char", {28'd0, tx_if.o_gt_tx_char}, {28'd0, e.c});
                    chk("underrun", {31'd0, tx_if.o_tx_underrun}, {31'd0, e.u});
                    if (e.gap >= 0) chk("ifg_gap", idle_cnt, e.gap);
                end
                idle_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_if.i_tx_axis_data  = 32'd0;
        tx_if.i_tx_axis_keep  = 4'h0;
        tx_if.i_tx_axis_valid = 1'b0;
        tx_if.i_tx_axis_last  = 1'b0;

        // Reset state and release timing.
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_data", tx_if.o_gt_tx_data, IDLE_W);
        chk("rst_char", {28'd0, tx_if.o_gt_tx_char}, {28'd0, IDLE_C});
        chk("rst_ready", {31'd0, tx_if.o_tx_axis_ready}, 32'd0);
        chk("rst_underrun", {31'd0, tx_if.o_tx_underrun}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("ifg1_ready", {31'd0, tx_if.o_tx_axis_ready}, 32'd0);
        chk("ifg1_data", tx_if.o_gt_tx_data, IDLE_W);
        @(posedge i_clk); #1;
        chk("idle_ready", {31'd0, tx_if.o_tx_axis_ready}, 32'd1);
        chk("idle_data", tx_if.o_gt_tx_data, IDLE_W);
        repeat (2) @(posedge i_clk);
        #1;

        // Two-beat frame, full last beat -> tail word.
        push(32'h332211FB, 4'b0001, 1'b0, -1);
        push(32'h77665544, 4'b0000, 1'b0, 0);
        push(32'h50BCFD88, 4'b0110, 1'b0, 0);
        send(32'h11223344, 4'hF, 1'b0);
        send(32'h55667788, 4'hF, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Single one-byte beat.
        push(32'h50FDABFB, 4'b0101, 1'b0, -1);
        send(32'hAB000000, 4'h8, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Single full beat; ready must drop during the tail cycle.
        push(32'hA3A2A1FB, 4'b0001, 1'b0, -1);
        push(32'h50BCFDA4, 4'b0110, 1'b0, 0);
        send(32'hA1A2A3A4, 4'hF, 1'b1);
        chk("tail_ready", {31'd0, tx_if.o_tx_axis_ready}, 32'd0);
        repeat (4) @(posedge i_clk);
        #1;

        // Two-byte last beat: FD in lane 3.
        push(32'hFDC2C1FB, 4'b1001, 1'b0, -1);
        send(32'hC1C20000, 4'hC, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Three-byte last beat: tail word is {FD, 50, BC, 50}.
        push(32'hD3D2D1FB, 4'b0001, 1'b0, -1);
        push(32'h50BC50FD, 4'b0101, 1'b0, 0);
        send(32'hD1D2D3D4, 4'hE, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Illegal keep on a last beat behaves as a full beat.
        push(32'hE3E2E1FB, 4'b0001, 1'b0, -1);
        push(32'h50BCFDE4, 4'b0110, 1'b0, 0);
        send(32'hE1E2E3E4, 4'h3, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Partial keep on a non-last beat is ignored.
        push(32'h030201FB, 4'b0001, 1'b0, -1);
        push(32'h50FD0504, 4'b0100, 1'b0, 0);
        send(32'h01020304, 4'h8, 1'b0);
        send(32'h05060708, 4'h8, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Back-to-back frames: exactly two idle words between EOF and SOF.
        push(32'h50FDABFB, 4'b0101, 1'b0, -1);
        push(32'h50FDCDFB, 4'b0101, 1'b0, 2);
        send(32'hAB000000, 4'h8, 1'b1);
        chk("ifg_ready", {31'd0, tx_if.o_tx_axis_ready}, 32'd0);
        send(32'hCD000000, 4'h8, 1'b1);
        repeat (4) @(posedge i_clk);
        #1;

        // Valid dropped after beat 1 of a 4-beat frame.
        push(32'h121110FB, 4'b0001, 1'b0, -1);
`ifdef PHY_TX_UNDERRUN_ABORT_EN
        push(32'h50BCFD13, 4'b0110, 1'b1, 0);
`else
        push(32'h22212013, 4'b0000, 1'b0, 2);
        push(32'h32313023, 4'b0000, 1'b0, 0);
        push(32'h42414033, 4'b0000, 1'b0, 0);
        push(32'h50BCFD43, 4'b0110, 1'b0, 0);
`endif
        send(32'h10111213, 4'hF, 1'b0);
        @(posedge i_clk); #1;
`ifdef PHY_TX_UNDERRUN_ABORT_EN
        chk("underrun_pulse", {31'd0, tx_if.o_tx_underrun}, 32'd1);
`else
        chk("underrun_pulse", {31'd0, tx_if.o_tx_underrun}, 32'd0);
`endif
        @(posedge i_clk); #1;
        chk("underrun_clear", {31'd0, tx_if.o_tx_underrun}, 32'd0);
        send(32'h20212223, 4'hF, 1'b0);
        send(32'h30313233, 4'hF, 1'b0);
        send(32'h40414243, 4'hF, 1'b1);
        repeat (10) @(posedge i_clk);
        #1;

        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
